// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
// The head entry is presented combinationally on dout whenever the FIFO is
// not empty, so a consumer may sample dout in the same cycle it pops.
// Status flags are pure decodes of the registered occupancy count. As a
// result, no combinational path exists from wr/rd/din to any output.
module sync_fifo #(
  parameter int WIDTH     = 96,
  parameter int DEPTH     = 16,
  parameter int AF_MARGIN = 2,
  parameter int AE_LEVEL  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             wr,
  input  logic             rd,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             half_full,
  output logic             almost_full,
  output logic             almost_empty
);

  localparam int AW = $clog2(DEPTH);

  // Flag thresholds, pre-sized to the count width so the compares stay
  // width-clean.
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] LVL_HALF = (AW+1)'(DEPTH / 2);
  localparam logic [AW:0] LVL_AF   = (AW+1)'(DEPTH - AF_MARGIN);
  localparam logic [AW:0] LVL_AE   = (AW+1)'(AE_LEVEL);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;

  logic rd_ok;
  logic wr_ok;

  // A pop needs data present. A push needs a free slot, or a pop in the same
  // cycle that frees one. This lets a full FIFO stream at full rate.
  assign rd_ok = rd & ~empty;
  assign wr_ok = wr & (~full | rd_ok);

  // Status flags decoded from the registered count only.
  assign full         = (count == LVL_FULL);
  assign empty        = (count == '0);
  assign half_full    = (count >= LVL_HALF);
  assign almost_full  = (count >= LVL_AF);
  assign almost_empty = (count <= LVL_AE);

  // Show-ahead head word. This value is meaningless while empty.
  assign dout = mem[rd_ptr];

  // Storage write port. Entries are captured on every accepted push.
  // NOTE: the storage array has no reset. Stale contents are never visible,
  // because empty gates every read, and leaving reset off keeps the array
  // mappable to plain RAM.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointer and occupancy bookkeeping. Reset takes priority over traffic.
  // NOTE: all sequential state uses non-blocking assignment. Every register
  // then samples the pre-edge values, with no order dependence between
  // the statements below.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo.
// A reference queue tracks the expected contents. The expected flag levels
// are written out as literal thresholds for DEPTH=16.
module tb_sync_fifo;

  logic        clk;
  logic        reset;
  logic [95:0] din;
  logic        wr;
  logic        rd;
  logic [95:0] dout;
  logic        full;
  logic        empty;
  logic        half_full;
  logic        almost_full;
  logic        almost_empty;

  int total;
  int bad;
  logic [95:0] ref_q [$];

  sync_fifo #(
    .WIDTH(96), .DEPTH(16), .AF_MARGIN(2), .AE_LEVEL(1)
  ) dut (
    .clk(clk), .reset(reset), .din(din), .wr(wr), .rd(rd), .dout(dout),
    .full(full), .empty(empty), .half_full(half_full),
    .almost_full(almost_full), .almost_empty(almost_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Flags as {full, empty, half_full, almost_full, almost_empty}. Checks the
  // head word too whenever data is expected.
  task automatic check_flags(input string tag);
    int n;
    logic [4:0] exp_f;
    logic [4:0] obs_f;
    n = ref_q.size();
    exp_f = {n == 16, n == 0, n >= 8, n >= 14, n <= 1};
    obs_f = {full, empty, half_full, almost_full, almost_empty};
    check_val({tag, "_flags"}, 96'(obs_f), 96'(exp_f));
    if (n > 0) begin
      check_val({tag, "_head"}, dout, ref_q[0]);
    end
  endtask

  // Runs one clock with the given request. Popped data is checked before the
  // edge, in the cycle rd is sampled. The flags are checked after the edge.
  task automatic cycle(input logic w, input logic r, input logic [95:0] d, input string tag);
    logic rd_ok;
    logic wr_ok;
    wr    = w;
    rd    = r;
    din   = d;
    rd_ok = r && (ref_q.size() > 0);
    wr_ok = w && ((ref_q.size() < 16) || rd_ok);
    if (rd_ok) begin
      check_val({tag, "_pop"}, dout, ref_q[0]);
    end
    @(posedge clk);
    #1;
    if (rd_ok) void'(ref_q.pop_front());
    if (wr_ok) ref_q.push_back(d);
    wr = 1'b0;
    rd = 1'b0;
    check_flags(tag);
  endtask

  task automatic do_reset(input logic w, input logic [95:0] d);
    reset = 1'b1;
    wr    = w;
    din   = d;
    @(posedge clk);
    #1;
    reset = 1'b0;
    wr    = 1'b0;
    ref_q.delete();
    check_flags("reset");
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    wr    = 1'b0;
    rd    = 1'b0;
    din   = '0;

    // Reset, then rd pulses on an empty FIFO.
    do_reset(1'b0, '0);
    cycle(1'b0, 1'b1, '0, "idle_rd0");
    cycle(1'b0, 1'b1, '0, "idle_rd1");

    // Fill with 1..16, then a dropped 17th write.
    for (int i = 1; i <= 16; i++) cycle(1'b1, 1'b0, 96'(i), "fill");
    check_val("full_after_fill", 96'(full), 96'(1));
    cycle(1'b1, 1'b0, 96'hFF, "overflow");

    // Drain in order, then an extra read on empty.
    for (int i = 1; i <= 16; i++) cycle(1'b0, 1'b1, '0, "drain");
    cycle(1'b0, 1'b1, '0, "underflow");
    check_val("empty_after_drain", 96'(empty), 96'(1));

    // Simultaneous read and write at count 5.
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 96'h20 + 96'(i), "fill5");
    cycle(1'b1, 1'b1, 96'hAA, "rw_at5");
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, '0, "drain5");

    // Simultaneous read and write at full.
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 96'h40 + 96'(i), "fill16");
    cycle(1'b1, 1'b1, 96'hBB, "rw_full");
    check_val("full_after_rw", 96'(full), 96'(1));
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, '0, "drain16");

    // Simultaneous read and write at empty: this is a write only.
    cycle(1'b1, 1'b1, 96'hCC, "rw_empty");
    check_val("dout_after_rw_empty", dout, 96'hCC);
    cycle(1'b0, 1'b1, '0, "drain_cc");

    // Wrap-around: three writes then two reads, repeated over 40 cycles.
    for (int i = 0; i < 40; i++) begin
      logic [95:0] v;
      v = {32'(i) ^ 32'h5A5A_0000, 32'hDEAD_0000 | 32'(i), ~32'(i)};
      if ((i % 5) < 3) cycle(1'b1, 1'b0, v, "wrap_wr");
      else             cycle(1'b0, 1'b1, '0, "wrap_rd");
    end
    while (ref_q.size() > 0) cycle(1'b0, 1'b1, '0, "wrap_drain");

    // Reset mid-operation, with a concurrent write, at count 9.
    for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0, 96'h60 + 96'(i), "fill9");
    do_reset(1'b1, 96'h99);
    check_val("empty_after_midreset", 96'(empty), 96'(1));
    check_val("half_after_midreset", 96'(half_full), 96'(0));
    cycle(1'b1, 1'b0, 96'h77, "post_reset_wr");
    check_val("post_reset_dout", dout, 96'h77);
    cycle(1'b0, 1'b1, '0, "post_reset_rd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
